// File: rtl/ex_bne_branch_unit_pkg.sv
// ex_bne_branch_unit_pkg: shared op encodings, FSM states and default widths for the EX branch unit
package ex_bne_branch_unit_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_BEQ = 2'b01, OP_BNE = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REDIR = 2'd1, SHADOW = 2'd2} state_e;
endpackage

// File: rtl/ex_bne_branch_unit_cmp.sv
// bne_branch_cmp: combinational BEQ/BNE condition, branch target and next-PC
module bne_branch_cmp
  import ex_bne_branch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_next_pc
);
  logic [XLEN-1:0] w_seq;
  logic            w_eq;
  assign w_seq     = i_pc + XLEN'(4);
  assign w_eq      = i_rs == i_rt;
  assign o_target  = w_seq + {i_imm[XLEN-3:0], 2'b00};
  assign o_taken   = (i_op == OP_BNE && !w_eq) || (i_op == OP_BEQ && w_eq);
  assign o_next_pc = o_taken ? o_target : w_seq;
endmodule

// File: rtl/ex_bne_branch_unit.sv
// ex_bne_branch_unit: EX-stage BEQ/BNE resolver driving the EX/BNE pipeline register,
// a fetch redirect handshake, a wrong-path shadow squash and a saturating taken counter
module ex_bne_branch_unit
  import ex_bne_branch_unit_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Tick,
  input  logic            ex_valid,
  input  logic [1:0]      ex_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs,
  input  logic [XLEN-1:0] ex_rt,
  input  logic            down_stall,
  input  logic            redir_ready,
  output logic            ex_ready,
  output logic            pipe_ce,
  output logic [XLEN:0]   pipe_d,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            squash,
  output logic [CNT_W-1:0] taken_cnt
);
  localparam logic [3:0] SHADOW_INIT = 4'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);
  state_e           r_state, w_next;
  logic [3:0]       r_shadow;
  logic [XLEN-1:0]  r_redir_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_taken, w_accept;
  logic [XLEN-1:0]  w_target, w_next_pc;
  bne_branch_cmp #(.XLEN(XLEN)) u_cmp (
    .i_op     (ex_op),
    .i_pc     (ex_pc),
    .i_imm    (ex_imm),
    .i_rs     (ex_rs),
    .i_rt     (ex_rt),
    .o_taken  (w_taken),
    .o_target (w_target),
    .o_next_pc(w_next_pc)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) r_state <= IDLE;
    else if (Tick) r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_accept && w_taken) ? REDIR : IDLE;
      REDIR:   w_next = redir_ready ? ((FLUSH_CYCLES == 0) ? IDLE : SHADOW) : REDIR;
      SHADOW:  w_next = (r_shadow == 4'd0) ? IDLE : SHADOW;
      default: w_next = IDLE;
    endcase
  end
  // SHADOW drains wrong-path slots unconditionally, so it ignores down_stall
  always_comb begin
    ex_ready    = (r_state == IDLE) ? !down_stall : (r_state == SHADOW);
    redir_valid = r_state == REDIR;
    squash      = (r_state == REDIR) || (r_state == SHADOW);
  end
  assign w_accept  = ex_valid && ex_ready && Tick;
  assign pipe_ce   = (r_state == IDLE) && w_accept;
  assign pipe_d    = {w_taken, w_next_pc};
  assign redir_pc  = r_redir_pc;
  assign taken_cnt = r_cnt;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      r_redir_pc <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
    end else if (Tick) begin
      if (pipe_ce && w_taken) begin
        r_redir_pc <= w_target;
        r_cnt      <= r_cnt + CNT_W'(r_cnt != '1);
      end
      if (r_state == REDIR && redir_ready) r_shadow <= SHADOW_INIT;
      if (r_state == SHADOW && r_shadow != 4'd0) r_shadow <= r_shadow - 4'd1;
    end
endmodule

// File: tb/tb_ex_bne_branch_unit.sv
// tb_ex_bne_branch_unit: directed test-plan scenarios plus randomized traffic checked
// against a slot-counting reference model; a second narrow-counter instance covers saturation
module tb_ex_bne_branch_unit;
  localparam int FLUSH = 2;
  logic        Clock = 0, Reset_n = 0, Tick = 0, ex_valid = 0, down_stall = 0, redir_ready = 0;
  logic [1:0]  ex_op = 0;
  logic [31:0] ex_pc = 0, ex_imm = 0, ex_rs = 0, ex_rt = 0;
  logic        ex_ready, pipe_ce, redir_valid, squash;
  logic [32:0] pipe_d;
  logic [31:0] redir_pc;
  logic [15:0] taken_cnt;
  logic        ex_ready2, pipe_ce2, redir_valid2, squash2;
  logic [32:0] pipe_d2;
  logic [31:0] redir_pc2;
  logic [3:0]  taken_cnt2;
  int          errors = 0, checks = 0;
  logic        m_pend;
  int          m_sh, m_cnt;
  logic [31:0] m_rpc;

  ex_bne_branch_unit #(.XLEN(32), .FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .down_stall(down_stall),
    .redir_ready(redir_ready), .ex_ready(ex_ready), .pipe_ce(pipe_ce), .pipe_d(pipe_d),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .squash(squash), .taken_cnt(taken_cnt)
  );
  ex_bne_branch_unit #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(4)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .down_stall(down_stall),
    .redir_ready(redir_ready), .ex_ready(ex_ready2), .pipe_ce(pipe_ce2), .pipe_d(pipe_d2),
    .redir_valid(redir_valid2), .redir_pc(redir_pc2), .squash(squash2), .taken_cnt(taken_cnt2)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_sh   = 0;
    m_cnt  = 0;
    m_rpc  = 0;
  endtask

  // compare current outputs against the model, then advance the model past the coming edge
  task automatic check_cycle();
    logic [31:0] seq, tgt, npc;
    logic        tk, exp_rdy, exp_ce;
    seq = ex_pc + 32'd4;
    tgt = seq + ex_imm * 32'd4;
    tk  = (ex_op == 2'b10 && ex_rs != ex_rt) || (ex_op == 2'b01 && ex_rs == ex_rt);
    npc = tk ? tgt : seq;
    if (m_pend) begin
      exp_rdy = 0;
      exp_ce  = 0;
    end else if (m_sh > 0) begin
      exp_rdy = 1;
      exp_ce  = 0;
    end else begin
      exp_rdy = !down_stall;
      exp_ce  = ex_valid && !down_stall && Tick;
    end
    chk("ex_ready", 64'(ex_ready), 64'(exp_rdy));
    chk("pipe_ce", 64'(pipe_ce), 64'(exp_ce));
    chk("redir_valid", 64'(redir_valid), 64'(m_pend));
    chk("squash", 64'(squash), 64'(m_pend || m_sh > 0));
    chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
    if (!m_pend && m_sh == 0) chk("pipe_d", 64'(pipe_d), 64'({tk, npc}));
    if (m_pend) chk("redir_pc", 64'(redir_pc), 64'(m_rpc));
    if (Tick) begin
      if (m_pend) begin
        if (redir_ready) begin
          m_pend = 0;
          m_sh   = FLUSH;
        end
      end else if (m_sh > 0) m_sh--;
      else if (exp_ce && tk) begin
        m_pend = 1;
        m_rpc  = tgt;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt, input logic st, input logic rr,
                      input logic tk);
    @(negedge Clock);
    ex_valid = v; ex_op = op; ex_pc = pc; ex_imm = imm; ex_rs = rs; ex_rt = rt;
    down_stall = st; redir_ready = rr; Tick = tk;
    #1;
    check_cycle();
  endtask

  task automatic idle_step(input logic rr);
    step(0, 2'b00, 0, 0, 0, 0, 0, rr, 1);
  endtask

  initial begin
    model_reset();
    #2;
    down_stall = 1;
    #1 chk("rst_ready_stall", 64'(ex_ready), 64'(0));
    down_stall = 0;
    #1 chk("rst_ready", 64'(ex_ready), 64'(1));
    chk("rst_rv", 64'(redir_valid), 64'(0));
    chk("rst_sq", 64'(squash), 64'(0));
    chk("rst_cnt", 64'(taken_cnt), 64'(0));
    chk("rst_rpc", 64'(redir_pc), 64'(0));
    @(negedge Clock) Reset_n = 1;

    // BNE taken, then redirect held off for three cycles
    step(1, 2'b10, 32'h100, 32'd3, 32'd5, 32'd7, 0, 0, 1);
    chk("bne_ce", 64'(pipe_ce), 64'(1));
    chk("bne_d", 64'(pipe_d), 64'h1_0000_0110);
    idle_step(0);
    chk("bne_rv", 64'(redir_valid), 64'(1));
    chk("bne_rpc", 64'(redir_pc), 64'h110);
    chk("bne_sq", 64'(squash), 64'(1));
    chk("bne_cnt", 64'(taken_cnt), 64'(1));
    idle_step(0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    chk("rr_no_tick", 64'(redir_valid), 64'(1));
    idle_step(0);
    idle_step(1);
    for (int i = 0; i < FLUSH; i++) begin
      step(1, 2'b10, 32'h200, 32'd1, 32'd1, 32'd2, 1, 0, 1);
      chk("shadow_ce", 64'(pipe_ce), 64'(0));
      chk("shadow_rdy", 64'(ex_ready), 64'(1));
    end
    idle_step(0);
    chk("post_shadow_sq", 64'(squash), 64'(0));

    // BEQ not taken
    step(1, 2'b01, 32'h100, 32'd3, 32'd9, 32'd8, 0, 0, 1);
    chk("beq_nt_d", 64'(pipe_d), 64'h0_0000_0104);
    idle_step(0);
    chk("beq_nt_sq", 64'(squash), 64'(0));

    // target wrap-around in both directions
    step(1, 2'b01, 32'hFFFF_FFFC, 32'd0, 32'd4, 32'd4, 0, 0, 1);
    chk("wrap0_d", 64'(pipe_d), 64'h1_0000_0000);
    idle_step(1);
    repeat (FLUSH) idle_step(0);
    step(1, 2'b01, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'd4, 32'd4, 0, 0, 1);
    chk("wrap1_d", 64'(pipe_d), 64'h1_FFFF_FFFC);
    idle_step(1);
    repeat (FLUSH) idle_step(0);

    // down_stall blocks the accept until released
    step(1, 2'b10, 32'h40, 32'd2, 32'd1, 32'd0, 1, 0, 1);
    chk("stall_rdy", 64'(ex_ready), 64'(0));
    chk("stall_ce", 64'(pipe_ce), 64'(0));
    step(1, 2'b10, 32'h40, 32'd2, 32'd1, 32'd0, 0, 0, 1);
    chk("unstall_sq", 64'(squash), 64'(0));
    chk("unstall_ce", 64'(pipe_ce), 64'(1));
    idle_step(0);
    chk("unstall_rpc", 64'(redir_pc), 64'h4C);

    // async reset in the middle of a redirect
    @(posedge Clock);
    #2 Reset_n = 0;
    #1 chk("arst_rv", 64'(redir_valid), 64'(0));
    chk("arst_sq", 64'(squash), 64'(0));
    chk("arst_ce", 64'(pipe_ce), 64'(0));
    chk("arst_cnt", 64'(taken_cnt), 64'(0));
    model_reset();
    @(negedge Clock) Reset_n = 1;
    idle_step(0);

    // saturation on the narrow-counter instance (FLUSH_CYCLES=0)
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b10, 32'h1000, 32'd5, 32'd1, 32'd2, 0, 0, 1);
      idle_step(1);
      idle_step(0);
      chk("nf_sq2", 64'(squash2), 64'(0));
      idle_step(0);
      chk("sat_cnt2", 64'(taken_cnt2), 64'((i + 1 > 15) ? 15 : i + 1));
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rs, rt, imm;
      rs  = $urandom_range(0, 3);
      rt  = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
      step(1'($urandom), 2'($urandom), {$urandom, 2'b00} >> 2 << 2, imm, rs, rt,
           $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
